// File: rtl/rv32_pkg.sv
// Shared rv32 core definitions: fetch FSM states, data width and the
// base-ISA major opcodes used by both fetch and the control unit.
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, IF/ID register
// with a one-entry hold buffer, and redirect flushing.
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] buf_pc, buf_instr;
    logic            req_c;
    logic            may_load;
    logic            ld_mem, ld_hold, ld_buf, flush;

    assign may_load  = !stall || !id_valid;
    assign imem_req  = req_c && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ISSUE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_c     = 1'b0;
        ld_mem    = 1'b0;
        ld_hold   = 1'b0;
        ld_buf    = 1'b0;
        flush     = 1'b0;
        case (state)
            ISSUE: begin
                req_c     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    pc_nxt = pc + 32'd4;
                    if (may_load) begin
                        ld_mem    = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        ld_buf    = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    ld_hold   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            DISCARD: begin
                if (imem_rvalid) state_nxt = ISSUE;
            end
            default: state_nxt = ISSUE;
        endcase

        // A redirect overrides all of the above. Whether a response is still
        // owed decides between dropping it later (DISCARD) or refetching now.
        if (redirect_valid) begin
            flush   = 1'b1;
            ld_mem  = 1'b0;
            ld_hold = 1'b0;
            ld_buf  = 1'b0;
            pc_nxt  = {redirect_pc[XLEN-1:2], 2'b00};
            if (state == ISSUE || ((state == WAIT || state == DISCARD) && !imem_rvalid))
                state_nxt = DISCARD;
            else
                state_nxt = ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (ld_mem) begin
            id_valid <= 1'b1;
            id_pc    <= pc;
            id_instr <= imem_rdata;
        end else if (ld_hold) begin
            id_valid <= 1'b1;
            id_pc    <= buf_pc;
            id_instr <= buf_instr;
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_pc    <= '0;
            buf_instr <= NOP_INSTR;
        end else if (ld_buf) begin
            buf_pc    <= pc;
            buf_instr <= imem_rdata;
        end
    end

    assign opcode = id_instr[6:0];
    assign func3  = id_instr[14:12];
    assign func7  = id_instr[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: inputs change just after negedge, outputs are
// checked 1ns later, and imem responses are driven cycle by cycle.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    int n_chk = 0;
    int n_err = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .opcode(opcode), .func3(func3), .func7(func7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word returned by the bench memory model for a given address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[24:0], 7'b0110011};
    endfunction

    task automatic cyc();
        @(negedge clk);
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req",      {31'd0, imem_req}, 32'd0);
        chk("rst_valid",    {31'd0, id_valid}, 32'd0);
        chk("rst_pc",       id_pc, 32'h0);
        chk("rst_instr",    id_instr, 32'h0000_0013);
        chk("rst_opcode",   {25'd0, opcode}, 32'h13);
        chk("rst_f3f7",     {22'd0, func3, func7}, 32'h0);

        // C0: first fetch
        rst = 1'b0; #1;
        chk("c0_req",  {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        // C1: 1-cycle memory response
        cyc(); imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
        chk("c1_req",  {31'd0, imem_req}, 32'd0);
        // C2: instruction visible, next request
        cyc(); #1;
        chk("c2_valid",  {31'd0, id_valid}, 32'd1);
        chk("c2_pc",     id_pc, 32'h0);
        chk("c2_instr",  id_instr, 32'h0050_0093);
        chk("c2_opcode", {25'd0, opcode}, 32'h13);
        chk("c2_func3",  {29'd0, func3}, 32'h0);
        chk("c2_req",    {31'd0, imem_req}, 32'd1);
        chk("c2_addr",   imem_addr, 32'h4);
        stall = 1'b1;
        // C3: response while stalled -> hold buffer
        cyc(); imem_rvalid = 1'b1; imem_rdata = mem(32'h4); #1;
        // C4: HOLD, IF/ID unchanged, no request
        cyc(); #1;
        chk("c4_req",   {31'd0, imem_req}, 32'd0);
        chk("c4_valid", {31'd0, id_valid}, 32'd1);
        chk("c4_pc",    id_pc, 32'h0);
        chk("c4_instr", id_instr, 32'h0050_0093);
        // C5: release stall
        cyc(); stall = 1'b0; #1;
        chk("c5_req",   {31'd0, imem_req}, 32'd0);
        // C6: buffered word in IF/ID, request to 0x8
        cyc(); #1;
        chk("c6_valid", {31'd0, id_valid}, 32'd1);
        chk("c6_pc",    id_pc, 32'h4);
        chk("c6_instr", id_instr, mem(32'h4));
        chk("c6_req",   {31'd0, imem_req}, 32'd1);
        chk("c6_addr",  imem_addr, 32'h8);
        // C7: WAIT, consumed instruction drops; redirect with no response
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        chk("c7_valid", {31'd0, id_valid}, 32'd0);
        // C8: DISCARD
        cyc(); #1;
        chk("c8_req",   {31'd0, imem_req}, 32'd0);
        // C9: late response gets dropped
        cyc(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        // C10: refetch at redirect target
        cyc(); #1;
        chk("c10_req",   {31'd0, imem_req}, 32'd1);
        chk("c10_addr",  imem_addr, 32'h100);
        chk("c10_valid", {31'd0, id_valid}, 32'd0);
        chk("c10_instr", id_instr, mem(32'h4));
        // C11: redirect coincident with response, misaligned target
        cyc(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        // C12: response dropped, immediate refetch at 0x100
        cyc(); #1;
        chk("c12_req",   {31'd0, imem_req}, 32'd1);
        chk("c12_addr",  imem_addr, 32'h100);
        chk("c12_valid", {31'd0, id_valid}, 32'd0);
        chk("c12_instr", id_instr, mem(32'h4));
        // C13: normal response
        cyc(); imem_rvalid = 1'b1; imem_rdata = mem(32'h100); #1;
        // C14: loaded; redirect during ISSUE to the top word
        cyc(); #1;
        chk("c14_valid", {31'd0, id_valid}, 32'd1);
        chk("c14_pc",    id_pc, 32'h100);
        chk("c14_addr",  imem_addr, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk("c14_req",   {31'd0, imem_req}, 32'd1);
        // C15: DISCARD eats the 0x104 response
        cyc(); imem_rvalid = 1'b1; imem_rdata = mem(32'h104); #1;
        chk("c15_valid", {31'd0, id_valid}, 32'd0);
        // C16: fetch at top of address space
        cyc(); #1;
        chk("c16_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("c16_req",   {31'd0, imem_req}, 32'd1);
        // C17
        cyc(); imem_rvalid = 1'b1; imem_rdata = mem(32'hFFFF_FFFC); #1;
        // C18: PC wraps to 0
        cyc(); #1;
        chk("c18_pc",    id_pc, 32'hFFFF_FFFC);
        chk("c18_func7", {25'd0, func7}, 32'h7F);
        chk("c18_addr",  imem_addr, 32'h0);
        chk("c18_req",   {31'd0, imem_req}, 32'd1);
        // C19: reset while waiting
        cyc(); rst = 1'b1; #1;
        // C20: reset state
        cyc(); #1;
        chk("c20_valid", {31'd0, id_valid}, 32'd0);
        chk("c20_instr", id_instr, 32'h0000_0013);
        chk("c20_req",   {31'd0, imem_req}, 32'd0);
        // C21: first request after reset
        cyc(); rst = 1'b0; #1;
        chk("c21_req",   {31'd0, imem_req}, 32'd1);
        chk("c21_addr",  imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
